// File: rtl/tl_pkg.sv
// rtl/tl_pkg.sv - shared light codes, phase/state enums and fault codes for traffic_light_monitor
package tl_pkg;

  localparam logic [1:0] TL_RED     = 2'b00;
  localparam logic [1:0] TL_YELLOW  = 2'b01;
  localparam logic [1:0] TL_GREEN   = 2'b10;
  localparam logic [1:0] TL_INVALID = 2'b11;

  typedef enum logic [1:0] {P0, P1, P2, P3} phase_t;

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} mon_state_t;

  localparam logic [2:0] FC_NONE        = 3'd0;
  localparam logic [2:0] FC_CONFLICT    = 3'd1;
  localparam logic [2:0] FC_INVALID     = 3'd2;
  localparam logic [2:0] FC_ILLEGAL     = 3'd3;
  localparam logic [2:0] FC_ORDER       = 3'd4;
  localparam logic [2:0] FC_DWELL_SHORT = 3'd5;
  localparam logic [2:0] FC_DWELL_LONG  = 3'd6;

  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(2'(p + 2'd1));
  endfunction

endpackage

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - combinational decode of {ns, ew} light codes into a phase and legality flags
module tl_phase_decode
  import tl_pkg::*;
(
  input  logic [1:0] ns,
  input  logic [1:0] ew,
  output phase_t     phase,
  output logic       legal,
  output logic       conflict,
  output logic       invalid
);

  always_comb begin
    phase    = P0;
    legal    = 1'b0;
    conflict = (ns == TL_GREEN) && (ew == TL_GREEN);
    invalid  = (ns == TL_INVALID) || (ew == TL_INVALID);
    case ({ns, ew})
      {TL_GREEN,  TL_RED}:    begin phase = P0; legal = 1'b1; end
      {TL_YELLOW, TL_RED}:    begin phase = P1; legal = 1'b1; end
      {TL_RED,    TL_GREEN}:  begin phase = P2; legal = 1'b1; end
      {TL_RED,    TL_YELLOW}: begin phase = P3; legal = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase order / dwell / conflict checker with sticky fault
// Long-dwell fault (code 6) enabled by TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN; otherwise dwell saturates.
module traffic_light_monitor
  import tl_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 15,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ns,
  input  logic [1:0]       ew,
  input  logic             clr,
  output logic             fault,
  output logic [2:0]       fault_code,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 1);

  mon_state_t    state;
  phase_t        cur_phase;
  phase_t        dec_phase;
  logic [DW-1:0] dwell;
  logic          legal, conflict, invalid;
  logic          same, advance;
  logic [2:0]    light_code;
  logic [2:0]    track_code;

  tl_phase_decode u_decode (
    .ns       (ns),
    .ew       (ew),
    .phase    (dec_phase),
    .legal    (legal),
    .conflict (conflict),
    .invalid  (invalid)
  );

  assign phase   = cur_phase;
  assign same    = (dec_phase == cur_phase);
  assign advance = (dec_phase == next_phase(cur_phase));

  // Light-level causes outrank sequence causes, so they are resolved first.
  always_comb begin
    light_code = FC_NONE;
    if (conflict)      light_code = FC_CONFLICT;
    else if (invalid)  light_code = FC_INVALID;
    else if (!legal)   light_code = FC_ILLEGAL;
  end

  always_comb begin
    track_code = light_code;
    if (light_code == FC_NONE) begin
      if (same) begin
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
        if (dwell == DW'(MAX_DWELL)) track_code = FC_DWELL_LONG;
`endif
      end else if (advance) begin
        if (dwell < DW'(MIN_DWELL)) track_code = FC_DWELL_SHORT;
      end else begin
        track_code = FC_ORDER;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SYNC;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      cur_phase   <= P0;
      phase_valid <= 1'b0;
      cycle_count <= '0;
      dwell       <= '0;
    end else if (clr) begin
      state       <= SYNC;
      fault       <= 1'b0;
      fault_code  <= FC_NONE;
      phase_valid <= 1'b0;
      dwell       <= '0;
    end else begin
      case (state)
        SYNC: begin
          if (light_code != FC_NONE) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_code  <= light_code;
            phase_valid <= 1'b0;
          end else begin
            state       <= TRACK;
            cur_phase   <= dec_phase;
            dwell       <= DW'(1);
            phase_valid <= 1'b1;
          end
        end
        TRACK: begin
          if (track_code != FC_NONE) begin
            state       <= FAULT;
            fault       <= 1'b1;
            fault_code  <= track_code;
            phase_valid <= 1'b0;
          end else if (advance) begin
            cur_phase <= dec_phase;
            dwell     <= DW'(1);
            if (cur_phase == P3) cycle_count <= cycle_count + 1'b1;
          end else if (dwell != DW'(MAX_DWELL)) begin
            dwell <= dwell + 1'b1;
          end
        end
        FAULT: ;
        default: state <= SYNC;
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - scoreboard bench for traffic_light_monitor with a reference model
module tb_traffic_light_monitor;

  localparam int MIN_D = 2;
  localparam int MAX_D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ns, ew;
  logic       clr;
  logic       fault;
  logic [2:0] fault_code;
  logic [1:0] phase;
  logic       phase_valid;
  logic [7:0] cycle_count;

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .ns          (ns),
    .ew          (ew),
    .clr         (clr),
    .fault       (fault),
    .fault_code  (fault_code),
    .phase       (phase),
    .phase_valid (phase_valid),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int f;
    int c;
    int p;
    int v;
    int cc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // {ns, ew} for phases P0..P3
  logic [3:0] pc [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  int m_faulted, m_locked, m_phase, m_dwell, m_cnt, m_code;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lookup(input logic [3:0] nsew);
    for (int i = 0; i < 4; i++) if (pc[i] == nsew) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_faulted = 0; m_locked = 0; m_phase = 0; m_dwell = 0; m_cnt = 0; m_code = 0;
  endtask

  task automatic model_fault(input int code);
    m_faulted = 1; m_locked = 0; m_code = code;
  endtask

  task automatic model_step(input logic [3:0] nsew, input logic c);
    int n, e, p, cause;
    n = int'(nsew[3:2]);
    e = int'(nsew[1:0]);
    p = lookup(nsew);
    if (c) begin
      m_faulted = 0; m_locked = 0; m_code = 0; m_dwell = 0;
      return;
    end
    if (m_faulted != 0) return;
    cause = 0;
    if (n == 2 && e == 2)      cause = 1;
    else if (n == 3 || e == 3) cause = 2;
    else if (p < 0)            cause = 3;
    if (cause != 0) begin
      model_fault(cause);
    end else if (m_locked == 0) begin
      m_locked = 1; m_phase = p; m_dwell = 1;
    end else if (p == m_phase) begin
      if (m_dwell >= MAX_D) begin
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
        model_fault(6);
`endif
      end else begin
        m_dwell++;
      end
    end else if (p == (m_phase + 1) % 4) begin
      if (m_dwell < MIN_D) model_fault(5);
      else begin
        if (m_phase == 3) m_cnt = (m_cnt + 1) % 256;
        m_phase = p;
        m_dwell = 1;
      end
    end else begin
      model_fault(4);
    end
  endtask

  // Drive one sample, let the edge take it, then queue what the DUT must show.
  task automatic step(input logic [3:0] nsew, input logic c);
    exp_t e;
    ns  = nsew[3:2];
    ew  = nsew[1:0];
    clr = c;
    @(posedge clk);
    #1;
    model_step(nsew, c);
    e.f  = m_faulted;
    e.c  = m_code;
    e.p  = m_phase;
    e.v  = (m_locked != 0 && m_faulted == 0) ? 1 : 0;
    e.cc = m_cnt;
    q.push_back(e);
  endtask

  task automatic run(input int p, input int n);
    for (int i = 0; i < n; i++) step(pc[p], 1'b0);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      chk("sb_fault",       int'(fault),       mon_e.f);
      chk("sb_fault_code",  int'(fault_code),  mon_e.c);
      chk("sb_phase",       int'(phase),       mon_e.p);
      chk("sb_phase_valid", int'(phase_valid), mon_e.v);
      chk("sb_cycle_count", int'(cycle_count), mon_e.cc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int g_phase, g_hold, r;
    rst = 1'b1; ns = 2'b00; ew = 2'b00; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_fault",       int'(fault),       0);
    chk("reset_fault_code",  int'(fault_code),  0);
    chk("reset_phase",       int'(phase),       0);
    chk("reset_phase_valid", int'(phase_valid), 0);
    chk("reset_cycle_count", int'(cycle_count), 0);
    rst = 1'b0;

    // legal sequence: three full cycles then P0
    for (int k = 0; k < 3; k++) for (int p = 0; p < 4; p++) run(p, 2);
    run(0, 1);
    chk("legal_cycle_count", int'(cycle_count), 3);
    chk("legal_phase",       int'(phase),       0);
    chk("legal_valid",       int'(phase_valid), 1);
    chk("legal_fault",       int'(fault),       0);

    // conflict, hold, clear, relock
    step(4'b1010, 1'b0);
    chk("conflict_code", int'(fault_code), 1);
    run(1, 2); run(2, 3);
    chk("conflict_hold", int'(fault_code), 1);
    step(pc[0], 1'b1);
    chk("clr_fault", int'(fault),       0);
    chk("clr_valid", int'(phase_valid), 0);
    run(0, 1);
    chk("relock_valid", int'(phase_valid), 1);

    // skipped phase, then invalid code from SYNC
    run(0, 1);
    run(2, 1);
    chk("skip_code", int'(fault_code), 4);
    step(pc[0], 1'b1);
    step(4'b1100, 1'b0);
    chk("invalid_code", int'(fault_code), 2);
    step(pc[0], 1'b1);

    // short dwell
    run(0, 3); run(1, 1); run(2, 1);
    chk("short_code", int'(fault_code), 5);
    step(pc[0], 1'b1);

    // long dwell
    run(0, 2); run(1, 5);
`ifdef TRAFFIC_LIGHT_MONITOR_TIMEOUT_EN
    chk("long_code", int'(fault_code), 6);
`else
    chk("long_nofault", int'(fault), 0);
    run(2, 1);
    chk("long_then_p2", int'(phase), 2);
`endif
    step(pc[0], 1'b1);

    // randomized traffic with occasional bad codes, skips and clears
    g_phase = 0; g_hold = 0;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if ((m_faulted != 0 && r < 30) || r < 2) begin
        step(pc[g_phase], 1'b1);
      end else if (r < 7) begin
        step(4'($urandom_range(0, 15)), 1'b0);
      end else begin
        if (g_hold == 0) begin
          g_phase = ($urandom_range(0, 9) == 0) ? (g_phase + 2) % 4 : (g_phase + 1) % 4;
          g_hold  = $urandom_range(1, 5);
        end
        step(pc[g_phase], 1'b0);
        g_hold--;
      end
    end

    // async reset mid-track, then first sample after release locks on P2
    step(pc[0], 1'b1);
    run(0, 2); run(1, 2); run(2, 1);
    #6;
    rst = 1'b1;
    #1;
    chk("async_fault",       int'(fault),       0);
    chk("async_fault_code",  int'(fault_code),  0);
    chk("async_phase",       int'(phase),       0);
    chk("async_phase_valid", int'(phase_valid), 0);
    chk("async_cycle_count", int'(cycle_count), 0);
    model_reset();
    ns = pc[2][3:2]; ew = pc[2][1:0]; clr = 1'b0;
    #1;
    rst = 1'b0;
    step(pc[2], 1'b0);
    chk("post_reset_phase", int'(phase),       2);
    chk("post_reset_valid", int'(phase_valid), 1);
    chk("post_reset_fault", int'(fault),       0);

    @(negedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
